// File: rtl/fetch_unit_if.sv
// fetch_unit_if: handshake and bus signals of the fetch front end.
// Groups the imem request/response, redirect and decode-side queue ports.
//   master: fetch_unit side (drives imem_req_*, inst_valid/out/pc)
//   slave : memory/decode/branch side (drives everything else)
interface fetch_unit_if #(
   parameter int XLEN = 32
);
   logic            imem_req_valid;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_req_ready;
   logic            imem_resp_valid;
   logic [31:0]     imem_resp_data;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            inst_valid;
   logic [31:0]     inst_out;
   logic [XLEN-1:0] inst_pc;
   logic            inst_ready;

   modport master (
      output imem_req_valid,
      output imem_req_addr,
      input  imem_req_ready,
      input  imem_resp_valid,
      input  imem_resp_data,
      input  redirect_valid,
      input  redirect_pc,
      output inst_valid,
      output inst_out,
      output inst_pc,
      input  inst_ready
   );

   modport slave (
      input  imem_req_valid,
      input  imem_req_addr,
      output imem_req_ready,
      output imem_resp_valid,
      output imem_resp_data,
      output redirect_valid,
      output redirect_pc,
      input  inst_valid,
      input  inst_out,
      input  inst_pc,
      output inst_ready
   );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: decoupled RV32I fetch; owns the PC, pipelines imem requests
// and queues {inst, pc} for decode; redirects squash the old path.
// Ports: clk, rst (sync, active-high), bus (fetch_unit_if.master):
//   imem_req_*/imem_resp_* to memory, redirect_* from branch resolution,
//   inst_valid/inst_out/inst_pc/inst_ready to decode.
// Option: define FETCH_JAL_PREDICT_EN to follow JAL targets on return.
module fetch_unit #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input logic          clk,
   input logic          rst,
   fetch_unit_if.master bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [XLEN-1:0] fetch_pc;

   logic [31:0]     q_inst [DEPTH];
   logic [XLEN-1:0] q_pc   [DEPTH];
   logic [AW-1:0]   q_head;
   logic [AW-1:0]   q_tail;
   logic [CW-1:0]   q_cnt;

   // PCs of accepted requests, in issue order
   logic [XLEN-1:0] f_pc [DEPTH];
   logic [AW-1:0]   f_head;
   logic [AW-1:0]   f_tail;
   logic [CW-1:0]   f_cnt;

   logic [CW-1:0]   discard;
   logic [31:0]     hold_inst;
   logic [XLEN-1:0] hold_pc;

   logic [CW:0]     used;
   logic            credit;
   logic            redir;
   logic            req_fire;
   logic            resp_fire;
   logic            drop;
   logic            keep;
   logic            jal_hit;
   logic            pop;
   logic            q_nempty;
   logic [31:0]     rdata;

   assign redir     = bus.redirect_valid;
   assign rdata     = bus.imem_resp_data;
   assign q_nempty  = q_cnt != '0;
   assign used      = {1'b0, q_cnt} + {1'b0, f_cnt};
   // queue slots are reserved at issue, so a return always has room
   assign credit    = used < (CW+1)'(DEPTH);

   // a stray response with nothing outstanding (e.g. after reset) is ignored
   assign resp_fire = ~rst & bus.imem_resp_valid & (f_cnt != '0);
   assign drop      = resp_fire & (discard != '0);
   assign keep      = resp_fire & (discard == '0) & ~redir;

`ifdef FETCH_JAL_PREDICT_EN
   logic [XLEN-1:0] jimm;
   assign jimm = {{(XLEN-20){rdata[31]}}, rdata[19:12],
                  rdata[20], rdata[30:21], 1'b0};
   assign jal_hit = keep & (rdata[6:0] == 7'b1101111);
`else
   assign jal_hit = 1'b0;
`endif

   assign bus.imem_req_valid = ~rst & ~redir & ~jal_hit & credit;
   assign bus.imem_req_addr  = fetch_pc;
   assign req_fire = bus.imem_req_valid & bus.imem_req_ready;

   assign bus.inst_valid = ~rst & q_nempty;
   assign bus.inst_out   = q_nempty ? q_inst[q_head] : hold_inst;
   assign bus.inst_pc    = q_nempty ? q_pc[q_head] : hold_pc;
   assign pop = bus.inst_valid & bus.inst_ready & ~redir;

   always_ff @(posedge clk) begin
      if (req_fire) f_pc[f_tail] <= fetch_pc;
      if (keep) begin
         q_inst[q_tail] <= rdata;
         q_pc[q_tail]   <= f_pc[f_head];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc  <= RESET_PC;
         q_head    <= '0;
         q_tail    <= '0;
         q_cnt     <= '0;
         f_head    <= '0;
         f_tail    <= '0;
         f_cnt     <= '0;
         discard   <= '0;
         hold_inst <= '0;
         hold_pc   <= '0;
      end else begin
         if (req_fire) f_tail <= f_tail + 1'b1;
         if (resp_fire) f_head <= f_head + 1'b1;
         f_cnt <= f_cnt + CW'(req_fire) - CW'(resp_fire);

         // keeps the last head visible once the queue drains or flushes
         if (q_nempty) begin
            hold_inst <= q_inst[q_head];
            hold_pc   <= q_pc[q_head];
         end

         if (redir) begin
            fetch_pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
            // everything still outstanding belongs to the old path
            discard  <= f_cnt - CW'(resp_fire);
            q_head   <= q_tail;
            q_cnt    <= '0;
         end else begin
`ifdef FETCH_JAL_PREDICT_EN
            if (jal_hit) begin
               fetch_pc <= f_pc[f_head] + jimm;
               discard  <= f_cnt - CW'(1);
            end else if (req_fire) begin
               fetch_pc <= fetch_pc + XLEN'(4);
            end else if (drop) begin
               discard <= discard - 1'b1;
            end
`else
            if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
            if (drop) discard <= discard - 1'b1;
`endif
            if (keep) q_tail <= q_tail + 1'b1;
            if (pop) q_head <= q_head + 1'b1;
            q_cnt <= q_cnt + CW'(keep) - CW'(pop);
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit with an in-order
// latency-programmable memory model and a path-following PC reference.
module tb_fetch_unit;

   logic clk;
   logic rst;

   fetch_unit_if #(.XLEN(32)) bus ();

   fetch_unit #(
      .XLEN(32),
      .DEPTH(4),
      .RESET_PC(32'h100)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } req_t;

   req_t pend[$];
   int   cyc;
   int   last_due;
   int   lat_min;
   int   lat_max;
   bit   jal_mode;

   bit          d_rst;
   bit          d_redir;
   logic [31:0] d_rpc;
   bit          d_iready;
   bit          d_rready;

   bit          o_req;
   bit          o_fire;
   bit          o_ival;
   bit          o_deliver;
   bit          o_resp;
   logic [31:0] o_addr;
   logic [31:0] o_ipc;
   logic [31:0] o_iout;

   int          total;
   int          bad;
   logic [31:0] exp_pc;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (jal_mode && a == 32'h0) return 32'h0100006F;
      return {a[26:2] ^ 25'h0A5A5A5, 7'b0010011};
   endfunction

   // next PC along the architecturally followed path
   function automatic logic [31:0] ref_next(input logic [31:0] pc,
                                            input logic [31:0] w);
`ifdef FETCH_JAL_PREDICT_EN
      int off;
      if (w[6:0] == 7'b1101111) begin
         off = 0;
         off[20]    = w[31];
         off[19:12] = w[19:12];
         off[11]    = w[20];
         off[10:1]  = w[30:21];
         if (w[31]) off = off - (1 << 21);
         return pc + off;
      end
`endif
      return pc + 32'd4;
   endfunction

   task automatic cycle();
      int l;
      int due;
      @(negedge clk);
      rst = d_rst;
      bus.redirect_valid = d_redir;
      bus.redirect_pc    = d_rpc;
      bus.inst_ready     = d_iready;
      bus.imem_req_ready = d_rready;
      o_resp = !d_rst && pend.size() > 0 && pend[0].due <= cyc;
      bus.imem_resp_valid = o_resp;
      bus.imem_resp_data  = o_resp ? mem_word(pend[0].addr) : 32'h0;
      #1;
      o_req     = bus.imem_req_valid;
      o_addr    = bus.imem_req_addr;
      o_fire    = o_req && d_rready;
      o_ival    = bus.inst_valid;
      o_ipc     = bus.inst_pc;
      o_iout    = bus.inst_out;
      o_deliver = o_ival && d_iready && !d_redir && !d_rst;
      @(posedge clk);
      if (d_rst) begin
         pend.delete();
         last_due = 0;
      end else begin
         if (o_resp) void'(pend.pop_front());
         if (o_fire) begin
            l   = $urandom_range(lat_max, lat_min);
            due = cyc + l;
            if (due <= last_due) due = last_due + 1;
            pend.push_back('{o_addr, due});
            last_due = due;
         end
      end
      cyc++;
   endtask

   task automatic do_reset();
      d_rst = 1; d_redir = 0; d_rpc = 0;
      d_iready = 0; d_rready = 1;
      lat_min = 1; lat_max = 1;
      repeat (2) cycle();
      d_rst = 0;
      cyc = 0;
      last_due = 0;
      exp_pc = 32'h100;
   endtask

   task automatic test_reset();
      d_rst = 1; d_redir = 0; d_rpc = 0;
      d_iready = 1; d_rready = 1;
      lat_min = 1; lat_max = 1;
      cycle();
      cycle();
      total++;
      if (o_req !== 1'b0 || o_ival !== 1'b0) begin
         bad++;
         $display("FAIL reset_outs req=%b ival=%b want 0 0", o_req, o_ival);
      end
      d_rst = 0; cyc = 0; last_due = 0;
      d_iready = 0;
      cycle();
      total++;
      if (o_ival !== 1'b0 || o_addr !== 32'h100) begin
         bad++;
         $display("FAIL reset_state ival=%b addr=%h want 0 00000100",
                  o_ival, o_addr);
      end
      total++;
      if ((^o_ipc) === 1'bx || (^o_iout) === 1'bx) begin
         bad++;
         $display("FAIL reset_x pc=%h inst=%h want known", o_ipc, o_iout);
      end
   endtask

   task automatic test_seq();
      int first;
      int nd;
      do_reset();
      d_iready = 1;
      first = -1; nd = 0;
      for (int i = 0; i < 20; i++) begin
         cycle();
         if (i < 3) begin
            total++;
            if (!o_fire || o_addr !== 32'h100 + 32'(4 * i)) begin
               bad++;
               $display("FAIL seq_addr%0d fire=%b addr=%h want 1 %h",
                        i, o_fire, o_addr, 32'h100 + 32'(4 * i));
            end
         end
         if (o_ival && first < 0) first = i;
         if (o_deliver) begin
            nd++; total++;
            if (o_ipc !== exp_pc || o_iout !== mem_word(exp_pc)) begin
               bad++;
               $display("FAIL seq_deliver pc=%h inst=%h want %h %h",
                        o_ipc, o_iout, exp_pc, mem_word(exp_pc));
            end
            exp_pc = ref_next(exp_pc, mem_word(exp_pc));
         end
      end
      total++;
      if (first != 2 || nd < 15) begin
         bad++;
         $display("FAIL seq_latency first=%0d n=%0d want 2 >=15", first, nd);
      end
   endtask

   task automatic test_full();
      int acc;
      int nd;
      do_reset();
      acc = 0; nd = 0;
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (o_fire) acc++;
      end
      total++;
      if (acc != 4 || o_req !== 1'b0 || o_ival !== 1'b1) begin
         bad++;
         $display("FAIL full_stall acc=%0d req=%b ival=%b want 4 0 1",
                  acc, o_req, o_ival);
      end
      d_iready = 1;
      for (int i = 0; i < 16; i++) begin
         cycle();
         if (o_deliver) begin
            nd++; total++;
            if (o_ipc !== exp_pc || o_iout !== mem_word(exp_pc)) begin
               bad++;
               $display("FAIL full_deliver pc=%h inst=%h want %h %h",
                        o_ipc, o_iout, exp_pc, mem_word(exp_pc));
            end
            exp_pc = ref_next(exp_pc, mem_word(exp_pc));
         end
      end
      total++;
      if (nd < 10) begin
         bad++;
         $display("FAIL full_drain n=%0d want >=10", nd);
      end
   endtask

   task automatic test_redirect_inflight();
      int first;
      do_reset();
      lat_min = 3; lat_max = 3;
      d_iready = 1;
      first = -1;
      for (int i = 0; i < 20; i++) begin
         d_redir = (i == 3);
         d_rpc   = 32'h203;
         cycle();
         if (i == 3) begin
            total++;
            if (o_req !== 1'b0) begin
               bad++;
               $display("FAIL redir_noreq req=%b want 0", o_req);
            end
            exp_pc = 32'h200;
         end
         if (i == 4) begin
            total++;
            if (!o_fire || o_addr !== 32'h200) begin
               bad++;
               $display("FAIL redir_addr fire=%b addr=%h want 1 00000200",
                        o_fire, o_addr);
            end
         end
         if (o_ival && first < 0) first = i;
         if (o_deliver) begin
            total++;
            if (o_ipc !== exp_pc || o_iout !== mem_word(exp_pc)) begin
               bad++;
               $display("FAIL redir_deliver pc=%h inst=%h want %h %h",
                        o_ipc, o_iout, exp_pc, mem_word(exp_pc));
            end
            exp_pc = ref_next(exp_pc, mem_word(exp_pc));
         end
      end
      d_redir = 0;
      total++;
      if (first != 8) begin
         bad++;
         $display("FAIL redir_first got=%0d want 8", first);
      end
   endtask

   task automatic test_redirect_full();
      int acc;
      int nd;
      do_reset();
      lat_min = 5; lat_max = 5;
      acc = 0; nd = 0;
      for (int i = 0; i < 8; i++) begin
         cycle();
         if (o_fire) acc++;
      end
      total++;
      if (acc != 4) begin
         bad++;
         $display("FAIL rfull_acc got=%0d want 4", acc);
      end
      d_redir = 1; d_rpc = 32'h400; d_iready = 1;
      cycle();
      total++;
      if (o_ival !== 1'b1 || o_ipc !== 32'h100) begin
         bad++;
         $display("FAIL rfull_head ival=%b pc=%h want 1 00000100",
                  o_ival, o_ipc);
      end
      exp_pc = 32'h400;
      d_redir = 0;
      cycle();
      total++;
      if (o_ival !== 1'b0 || o_ipc !== 32'h100 ||
          !o_fire || o_addr !== 32'h400) begin
         bad++;
         $display("FAIL rfull_flush ival=%b pc=%h fire=%b addr=%h want 0 100 1 400",
                  o_ival, o_ipc, o_fire, o_addr);
      end
      for (int i = 0; i < 14; i++) begin
         cycle();
         if (o_deliver) begin
            nd++; total++;
            if (o_ipc !== exp_pc || o_iout !== mem_word(exp_pc)) begin
               bad++;
               $display("FAIL rfull_deliver pc=%h inst=%h want %h %h",
                        o_ipc, o_iout, exp_pc, mem_word(exp_pc));
            end
            exp_pc = ref_next(exp_pc, mem_word(exp_pc));
         end
      end
      total++;
      if (nd < 1) begin
         bad++;
         $display("FAIL rfull_progress n=%0d want >=1", nd);
      end
   endtask

   task automatic test_wrap();
      int nd;
      do_reset();
      d_iready = 1;
      d_redir = 1; d_rpc = 32'hFFFF_FFFE;
      cycle();
      d_redir = 0;
      exp_pc = 32'hFFFF_FFFC;
      nd = 0;
      for (int i = 1; i < 12; i++) begin
         cycle();
         if (i == 1 || i == 2) begin
            total++;
            if (!o_fire || o_addr !== (i == 1 ? 32'hFFFF_FFFC : 32'h0)) begin
               bad++;
               $display("FAIL wrap_addr%0d fire=%b addr=%h", i, o_fire, o_addr);
            end
         end
         if (o_deliver) begin
            nd++; total++;
            if (o_ipc !== exp_pc || o_iout !== mem_word(exp_pc)) begin
               bad++;
               $display("FAIL wrap_deliver pc=%h inst=%h want %h %h",
                        o_ipc, o_iout, exp_pc, mem_word(exp_pc));
            end
            exp_pc = ref_next(exp_pc, mem_word(exp_pc));
         end
      end
      total++;
      if (nd < 3) begin
         bad++;
         $display("FAIL wrap_progress n=%0d want >=3", nd);
      end
   endtask

   task automatic test_jal();
      do_reset();
      jal_mode = 1;
      lat_min = 3; lat_max = 3;
      d_iready = 1;
      d_redir = 1; d_rpc = 32'h0;
      cycle();
      d_redir = 0;
      exp_pc = 32'h0;
      for (int i = 1; i < 22; i++) begin
         cycle();
`ifdef FETCH_JAL_PREDICT_EN
         if (i == 4) begin
            total++;
            if (o_req !== 1'b0) begin
               bad++;
               $display("FAIL jal_noreq req=%b want 0", o_req);
            end
         end
         if (i == 5) begin
            total++;
            if (!o_fire || o_addr !== 32'h10) begin
               bad++;
               $display("FAIL jal_target fire=%b addr=%h want 1 00000010",
                        o_fire, o_addr);
            end
         end
`else
         if (i == 4) begin
            total++;
            if (!o_fire || o_addr !== 32'hC) begin
               bad++;
               $display("FAIL jal_seq fire=%b addr=%h want 1 0000000c",
                        o_fire, o_addr);
            end
         end
`endif
         if (o_deliver) begin
            total++;
            if (o_ipc !== exp_pc || o_iout !== mem_word(exp_pc)) begin
               bad++;
               $display("FAIL jal_deliver pc=%h inst=%h want %h %h",
                        o_ipc, o_iout, exp_pc, mem_word(exp_pc));
            end
            exp_pc = ref_next(exp_pc, mem_word(exp_pc));
         end
      end
      total++;
      if (exp_pc < 32'h18) begin
         bad++;
         $display("FAIL jal_progress next=%h want >=18", exp_pc);
      end
      jal_mode = 0;
   endtask

   task automatic test_mid_reset();
      do_reset();
      for (int i = 0; i < 6; i++) cycle();
      d_rst = 1;
      cycle();
      total++;
      if (o_ival !== 1'b0 || o_req !== 1'b0) begin
         bad++;
         $display("FAIL mrst_during ival=%b req=%b want 0 0", o_ival, o_req);
      end
      d_rst = 0;
      exp_pc = 32'h100;
      cycle();
      total++;
      if (o_ival !== 1'b0 || o_addr !== 32'h100) begin
         bad++;
         $display("FAIL mrst_after ival=%b addr=%h want 0 00000100",
                  o_ival, o_addr);
      end
      d_iready = 1;
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (o_deliver) begin
            total++;
            if (o_ipc !== exp_pc || o_iout !== mem_word(exp_pc)) begin
               bad++;
               $display("FAIL mrst_deliver pc=%h inst=%h want %h %h",
                        o_ipc, o_iout, exp_pc, mem_word(exp_pc));
            end
            exp_pc = ref_next(exp_pc, mem_word(exp_pc));
         end
      end
   endtask

   task automatic test_random();
      int nd;
      do_reset();
      lat_min = 1; lat_max = 4;
      nd = 0;
      for (int i = 0; i < 1500; i++) begin
         d_iready = ($urandom % 4) != 0;
         d_rready = ($urandom % 4) != 0;
         d_redir  = ($urandom % 29) == 0;
         d_rpc    = $urandom;
         d_rst    = ($urandom % 300) == 0;
         cycle();
         if (o_req) begin
            total++;
            if (o_addr[1:0] !== 2'b00) begin
               bad++;
               $display("FAIL rnd_align addr=%h want low bits 00", o_addr);
            end
         end
         total++;
         if (pend.size() > 4) begin
            bad++;
            $display("FAIL rnd_outstanding got=%0d want <=4", pend.size());
         end
         if (o_deliver) begin
            nd++; total++;
            if (o_ipc !== exp_pc || o_iout !== mem_word(exp_pc)) begin
               bad++;
               $display("FAIL rnd_deliver pc=%h inst=%h want %h %h",
                        o_ipc, o_iout, exp_pc, mem_word(exp_pc));
            end
            exp_pc = ref_next(exp_pc, mem_word(exp_pc));
         end
         if (d_rst) exp_pc = 32'h100;
         else if (d_redir) exp_pc = {d_rpc[31:2], 2'b00};
      end
      d_rst = 0; d_redir = 0;
      total++;
      if (nd < 200) begin
         bad++;
         $display("FAIL rnd_progress n=%0d want >=200", nd);
      end
   endtask

   initial begin
      clk = 0;
      rst = 1;
      bus.imem_req_ready  = 0;
      bus.imem_resp_valid = 0;
      bus.imem_resp_data  = 0;
      bus.redirect_valid  = 0;
      bus.redirect_pc     = 0;
      bus.inst_ready      = 0;
      total = 0; bad = 0;
      cyc = 0; last_due = 0;
      jal_mode = 0;
      test_reset();
      test_seq();
      test_full();
      test_redirect_inflight();
      test_redirect_full();
      test_wrap();
      test_jal();
      test_mid_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
